// File: rtl/eth_decap_core_if.sv
// RX AXI-stream beat bundle from the 10G MAC into the NetTLP decapsulator.
// The MAC drives (master); the decapsulator only observes (slave). No tready exists.
interface eth_decap_core_if;
    logic        eth_tvalid;
    logic        eth_tlast;
    logic [7:0]  eth_tkeep;
    logic [63:0] eth_tdata;
    logic        eth_tuser;

    modport master (output eth_tvalid, eth_tlast, eth_tkeep, eth_tdata, eth_tuser);
    modport slave  (input  eth_tvalid, eth_tlast, eth_tkeep, eth_tdata, eth_tuser);
endinterface

// File: rtl/eth_decap_core.sv
// NetTLP receive decapsulator: validates the 48-byte Eth/IPv4/UDP/NetTLP header and steers
// payload to the TLP FIFO or one command qword to the command FIFO. Define ETH_DECAP_IPCHECK_EN to verify the IP checksum.
module eth_decap_core #(
    parameter logic [15:0] eth_proto = 16'h0800,
    parameter int unsigned sync_idle = 16
) (
    input  logic        eth_clk,
    input  logic        eth_rst,
    eth_decap_core_if.slave rx,
    input  logic [47:0] adapter_reg_srcmac,
    input  logic [31:0] adapter_reg_srcip,
    output logic        tlp_wr_en,
    output logic [63:0] tlp_din_tdata,
    output logic [7:0]  tlp_din_tkeep,
    output logic        tlp_din_tlast,
    output logic        tlp_din_terr,
    input  logic        tlp_full,
    input  logic        tlp_prog_full,
    output logic        cmd_wr_en,
    output logic [63:0] cmd_din,
    input  logic        cmd_full,
    output logic [31:0] stat_rx_ok,
    output logic [31:0] stat_rx_drop,
    output logic [31:0] stat_ovf,
    output logic [15:0] last_seq
);
    localparam logic [15:0] UDP_PORT_NETTLP_MR  = 16'h3000;
    localparam logic [15:0] UDP_PORT_NETTLP_CPL = 16'h4000;
    localparam logic [15:0] UDP_NETTLP_CMD_PORT = 16'h5000;
    localparam logic [15:0] SYNC_LAST = 16'(sync_idle - 1);

    typedef enum logic [2:0] {RX_SYNC, RX_HDR, RX_TLP, RX_CMD, RX_DROP} rx_state_t;
    rx_state_t state, state_n;

    logic [2:0]  hdr_cnt, hdr_cnt_n;
    logic        hdr_bad, hdr_bad_n, cls_tlp, cls_tlp_n;
    logic [15:0] idle_cnt, idle_cnt_n;
    logic        err_pend, err_pend_n, term_pend, term_pend_n, cmd_done, cmd_done_n;
    logic        beat, tlast, beat_bad, dport_tlp, dport_cmd, csum_bad;
    logic [63:0] d, d_swap;
    logic [47:0] dst_mac;
    logic [15:0] dport;

    logic        tlp_wr_en_n, tlp_last_n, tlp_err_n, cmd_wr_en_n;
    logic [63:0] tlp_data_n, cmd_din_n;
    logic [7:0]  tlp_keep_n;
    logic [15:0] last_seq_n;
    logic        ok_inc, drop_inc, ovf_inc;

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    assign beat    = rx.eth_tvalid;
    assign tlast   = rx.eth_tlast;
    assign d       = rx.eth_tdata;
    assign d_swap  = {bswap32(d[63:32]), bswap32(d[31:0])};
    assign dst_mac = {d[7:0], d[15:8], d[23:16], d[31:24], d[39:32], d[47:40]};
    assign dport   = {d[39:32], d[47:40]};

    always_comb begin
        dport_tlp = (dport >= UDP_PORT_NETTLP_MR  && dport <= UDP_PORT_NETTLP_MR  + 16'd15) ||
                    (dport >= UDP_PORT_NETTLP_CPL && dport <= UDP_PORT_NETTLP_CPL + 16'd255);
        dport_cmd = (dport == UDP_NETTLP_CMD_PORT);
        beat_bad  = 1'b0;
        case (hdr_cnt)
            3'd0: beat_bad = !(dst_mac == adapter_reg_srcmac || dst_mac == '1);
            3'd1: beat_bad = ({d[39:32], d[47:40]} != eth_proto) || (d[55:48] != 8'h45);
            3'd2: beat_bad = (d[63:56] != 8'd17);
            3'd3: beat_bad = ({d[55:48], d[63:56]} != adapter_reg_srcip[31:16]);
            3'd4: beat_bad = ({d[7:0], d[15:8]} != adapter_reg_srcip[15:0]) || !(dport_tlp || dport_cmd);
            default: beat_bad = 1'b0;
        endcase
    end

`ifdef ETH_DECAP_IPCHECK_EN
    logic [15:0] csum, csum_n;

    function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    // IP header spans q1 word 3, all of q2 and q3, and q4 word 0.
    always_comb begin
        csum_n = (hdr_cnt == 3'd0) ? '0 : csum;
        for (int unsigned k = 0; k < 4; k++) begin
            if ((hdr_cnt == 3'd1 && k == 3) || hdr_cnt == 3'd2 || hdr_cnt == 3'd3 ||
                (hdr_cnt == 3'd4 && k == 0))
                csum_n = oc_add(csum_n, {d[16*k +: 8], d[16*k+8 +: 8]});
        end
        csum_bad = (hdr_cnt == 3'd4) && (csum_n != 16'hFFFF);
    end

    always_ff @(posedge eth_clk) begin
        if (eth_rst)
            csum <= '0;
        else if (state == RX_HDR && beat)
            csum <= csum_n;
    end
`else
    assign csum_bad = 1'b0;
`endif

    always_ff @(posedge eth_clk) begin
        if (eth_rst) begin
            state    <= RX_SYNC;
            hdr_cnt  <= '0;
            hdr_bad  <= 1'b0;
            cls_tlp  <= 1'b0;
            idle_cnt <= '0;
        end else begin
            state    <= state_n;
            hdr_cnt  <= hdr_cnt_n;
            hdr_bad  <= hdr_bad_n;
            cls_tlp  <= cls_tlp_n;
            idle_cnt <= idle_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        hdr_cnt_n  = hdr_cnt;
        hdr_bad_n  = hdr_bad;
        cls_tlp_n  = cls_tlp;
        idle_cnt_n = '0;
        case (state)
            RX_SYNC: begin
                if (beat) begin
                    if (tlast) state_n = RX_HDR;
                end else if (idle_cnt == SYNC_LAST) begin
                    state_n = RX_HDR;
                end else begin
                    idle_cnt_n = idle_cnt + 16'd1;
                end
                hdr_cnt_n = '0;
            end
            RX_HDR: if (beat) begin
                hdr_bad_n = ((hdr_cnt == 3'd0) ? 1'b0 : hdr_bad) | beat_bad | csum_bad;
                if (hdr_cnt == 3'd4) cls_tlp_n = dport_tlp;
                if (tlast) begin
                    hdr_cnt_n = '0;
                end else if (hdr_cnt == 3'd5) begin
                    hdr_cnt_n = '0;
                    if (hdr_bad)                      state_n = RX_DROP;
                    else if (cls_tlp && tlp_prog_full) state_n = RX_DROP;
                    else if (cls_tlp)                 state_n = RX_TLP;
                    else                              state_n = RX_CMD;
                end else begin
                    hdr_cnt_n = hdr_cnt + 3'd1;
                end
            end
            RX_TLP, RX_CMD, RX_DROP: if (beat && tlast) state_n = RX_HDR;
            default: state_n = RX_SYNC;
        endcase
    end

    // A pending terminator takes the write slot first; a payload beat colliding with it is treated as lost.
    always_comb begin
        tlp_wr_en_n = 1'b0;
        tlp_data_n  = tlp_din_tdata;
        tlp_keep_n  = tlp_din_tkeep;
        tlp_last_n  = tlp_din_tlast;
        tlp_err_n   = tlp_din_terr;
        cmd_wr_en_n = 1'b0;
        cmd_din_n   = cmd_din;
        last_seq_n  = last_seq;
        err_pend_n  = err_pend;
        term_pend_n = term_pend;
        cmd_done_n  = cmd_done;
        ok_inc      = 1'b0;
        drop_inc    = 1'b0;
        ovf_inc     = 1'b0;

        if (term_pend && !tlp_full) begin
            tlp_wr_en_n = 1'b1;
            tlp_data_n  = '0;
            tlp_keep_n  = '0;
            tlp_last_n  = 1'b1;
            tlp_err_n   = 1'b1;
            term_pend_n = 1'b0;
            err_pend_n  = 1'b0;
        end

        case (state)
            RX_HDR: if (beat) begin
                if (tlast) drop_inc = 1'b1;
                else if (hdr_cnt == 3'd5 && (state_n == RX_TLP || state_n == RX_CMD)) begin
                    last_seq_n = {d[23:16], d[31:24]};
                    cmd_done_n = 1'b0;
                end
            end
            RX_TLP: if (beat) begin
                if (tlp_full || term_pend) begin
                    ovf_inc    = 1'b1;
                    err_pend_n = 1'b1;
                    if (tlast) term_pend_n = 1'b1;
                end else begin
                    tlp_wr_en_n = 1'b1;
                    tlp_data_n  = d_swap;
                    tlp_keep_n  = rx.eth_tkeep;
                    tlp_last_n  = tlast;
                    tlp_err_n   = err_pend | (tlast & rx.eth_tuser);
                    err_pend_n  = 1'b0;
                end
                if (tlast) begin
                    ok_inc   = !rx.eth_tuser;
                    drop_inc = rx.eth_tuser;
                end
            end
            RX_CMD: if (beat) begin
                if (!cmd_done) begin
                    cmd_done_n = 1'b1;
                    if (cmd_full) ovf_inc = 1'b1;
                    else begin
                        cmd_wr_en_n = 1'b1;
                        cmd_din_n   = d_swap;
                    end
                end
                if (tlast) begin
                    ok_inc   = !rx.eth_tuser;
                    drop_inc = rx.eth_tuser;
                end
            end
            RX_DROP: if (beat && tlast) drop_inc = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge eth_clk) begin
        if (eth_rst) begin
            tlp_wr_en     <= 1'b0;
            tlp_din_tdata <= '0;
            tlp_din_tkeep <= '0;
            tlp_din_tlast <= 1'b0;
            tlp_din_terr  <= 1'b0;
            cmd_wr_en     <= 1'b0;
            cmd_din       <= '0;
            stat_rx_ok    <= '0;
            stat_rx_drop  <= '0;
            stat_ovf      <= '0;
            last_seq      <= '0;
            err_pend      <= 1'b0;
            term_pend     <= 1'b0;
            cmd_done      <= 1'b0;
        end else begin
            tlp_wr_en     <= tlp_wr_en_n;
            tlp_din_tdata <= tlp_data_n;
            tlp_din_tkeep <= tlp_keep_n;
            tlp_din_tlast <= tlp_last_n;
            tlp_din_terr  <= tlp_err_n;
            cmd_wr_en     <= cmd_wr_en_n;
            cmd_din       <= cmd_din_n;
            stat_rx_ok    <= stat_rx_ok + {31'd0, ok_inc};
            stat_rx_drop  <= stat_rx_drop + {31'd0, drop_inc};
            stat_ovf      <= stat_ovf + {31'd0, ovf_inc};
            last_seq      <= last_seq_n;
            err_pend      <= err_pend_n;
            term_pend     <= term_pend_n;
            cmd_done      <= cmd_done_n;
        end
    end
endmodule
